// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage.
// Holds funct3 widths, the access FSM states and the latched instruction bundle.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } mem_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [2:0]  funct3;
        logic        mem_write;
        logic        regwrite_en;
    } ex_mem_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane formatting for stores and loads.
// Purely combinational; misalign only reflects halfword/word offsets.
module mem_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic        misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{off, 3'b000} +: 8];
        half_v     = off[1] ? rdata[31:16] : rdata[15:0];
        wstrb      = 4'b0000;
        wdata      = store_data;
        load_value = rdata;
        misalign   = 1'b0;
        unique case (1'b1)
            (funct3 == F3_B): begin
                wstrb      = 4'b0001 << off;
                wdata      = {4{store_data[7:0]}};
                load_value = {{24{byte_v[7]}}, byte_v};
            end
            (funct3 == F3_BU): begin
                load_value = {24'b0, byte_v};
            end
            (funct3 == F3_H): begin
                wstrb      = 4'b0011 << off;
                wdata      = {2{store_data[15:0]}};
                load_value = {{16{half_v[15]}}, half_v};
                misalign   = off[0];
            end
            (funct3 == F3_HU): begin
                load_value = {16'b0, half_v};
                misalign   = off[0];
            end
            (funct3 == F3_W): begin
                wstrb    = 4'b1111;
                misalign = |off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: one outstanding data-memory access at a time.
// All handshake and writeback outputs are registered.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_regwrite_en,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_regwrite_en,
    output logic              access_err
);

    mem_state_t  state;
    ex_mem_t     q;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;
    logic        is_mem;
    logic        bad_f3;
    logic        err;

    // In IDLE the aligner formats the incoming store; afterwards it decodes the load.
    assign al_f3  = (state == IDLE) ? ex_funct3 : q.funct3;
    assign al_off = (state == IDLE) ? ex_alu_result[1:0] : q.alu[1:0];

    mem_align u_align (
        .funct3     (al_f3),
        .off        (al_off),
        .store_data (ex_store_data),
        .rdata      (dmem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_value (al_load),
        .misalign   (al_misalign)
    );

    always_comb begin
        is_mem = ex_mem_read | ex_mem_write;
        bad_f3 = 1'b0;
        if (ex_mem_write)
            bad_f3 = !(ex_funct3 inside {F3_B, F3_H, F3_W});
        else if (ex_mem_read)
            bad_f3 = !(ex_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        err = is_mem & (bad_f3 | al_misalign | (ex_mem_read & ex_mem_write));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            q              <= '0;
            ex_ready       <= 1'b1;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= '0;
            dmem_we        <= 1'b0;
            dmem_wstrb     <= 4'b0;
            dmem_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= '0;
            wb_regwrite_en <= 1'b0;
            access_err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ex_valid && ex_ready) begin
                        ex_ready      <= 1'b0;
                        q.rd          <= ex_rd;
                        q.alu         <= ex_alu_result;
                        q.funct3      <= ex_funct3;
                        q.mem_write   <= ex_mem_write;
                        q.regwrite_en <= ex_regwrite_en;
                        if (!is_mem || err) begin
                            state          <= DONE;
                            wb_valid       <= 1'b1;
                            wb_rd          <= ex_rd;
                            wb_data        <= ex_alu_result;
                            wb_regwrite_en <= !err && ex_regwrite_en
                                              && (ex_rd != 5'd0);
                            access_err     <= err;
                        end else begin
                            state          <= REQ;
                            dmem_req_valid <= 1'b1;
                            dmem_addr      <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            dmem_we        <= ex_mem_write;
                            dmem_wstrb     <= ex_mem_write ? al_wstrb : 4'b0;
                            dmem_wdata     <= ex_mem_write ? al_wdata : '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        dmem_addr      <= '0;
                        dmem_we        <= 1'b0;
                        dmem_wstrb     <= 4'b0;
                        dmem_wdata     <= '0;
                        if (q.mem_write) begin
                            state          <= DONE;
                            wb_valid       <= 1'b1;
                            wb_rd          <= q.rd;
                            wb_data        <= q.alu;
                            wb_regwrite_en <= 1'b0;
                            access_err     <= 1'b0;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        state          <= DONE;
                        wb_valid       <= 1'b1;
                        wb_rd          <= q.rd;
                        wb_data        <= al_load;
                        wb_regwrite_en <= q.regwrite_en && (q.rd != 5'd0);
                        access_err     <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    ex_ready   <= 1'b1;
                    wb_valid   <= 1'b0;
                    access_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
// Expected writebacks are queued at issue and popped on each wb_valid.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_regwrite_en;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_regwrite_en;
    logic        access_err;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rd          (ex_rd),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_funct3      (ex_funct3),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_regwrite_en (ex_regwrite_en),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_regwrite_en (wb_regwrite_en),
        .access_err     (access_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data,
                        input logic we, input logic err);
        exp_t e;
        e.rd = rd; e.data = data; e.we = we; e.err = err;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                check("spurious_wb", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_data", wb_data, e.data);
                check("wb_we", 32'(wb_regwrite_en), 32'(e.we));
                check("wb_err", 32'(access_err), 32'(e.err));
            end
        end
    end

    task automatic issue(input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [2:0] f3,
                         input logic rd_en, input logic wr_en,
                         input logic rwe);
        ex_valid       = 1'b1;
        ex_rd          = rd;
        ex_alu_result  = alu;
        ex_store_data  = sd;
        ex_funct3      = f3;
        ex_mem_read    = rd_en;
        ex_mem_write   = wr_en;
        ex_regwrite_en = rwe;
        for (int i = 0; i < 20 && !ex_ready; i++) tick();
        check("ex_ready", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic do_mem(input string tag, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic [2:0] f3, input logic wr_en,
                          input logic [3:0] strb, input logic [31:0] wd,
                          input logic [31:0] rdata, input int hold,
                          input int lat);
        issue(rd, alu, sd, f3, !wr_en, wr_en, !wr_en);
        for (int i = 0; i < 10 && !dmem_req_valid; i++) tick();
        for (int i = 0; i <= hold; i++) begin
            check({tag, "_req"}, 32'(dmem_req_valid), 32'd1);
            check({tag, "_addr"}, dmem_addr, {alu[31:2], 2'b00});
            check({tag, "_we"}, 32'(dmem_we), 32'(wr_en));
            check({tag, "_strb"}, 32'(dmem_wstrb), 32'(strb));
            if (wr_en) check({tag, "_wdata"}, dmem_wdata, wd);
            if (i < hold) tick();
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        if (!wr_en) begin
            check({tag, "_nowb_early"}, 32'(wb_valid), 32'd0);
            repeat (lat) tick();
            dmem_rsp_valid = 1'b1;
            dmem_rdata     = rdata;
            tick();
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = 32'h5A5A_5A5A;
        end
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        ex_valid       = 1'b0;
        ex_rd          = 5'd0;
        ex_alu_result  = 32'd0;
        ex_store_data  = 32'd0;
        ex_funct3      = 3'd0;
        ex_mem_read    = 1'b0;
        ex_mem_write   = 1'b0;
        ex_regwrite_en = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        repeat (2) tick();
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_req", 32'(dmem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_strb", 32'(dmem_wstrb), 32'd0);
        rst = 1'b0;
        tick();

        push(5'd5, 32'h0000_1234, 1'b1, 1'b0);
        issue(5'd5, 32'h0000_1234, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        check("nm_latency", 32'(wb_valid), 32'd1);
        tick();

        push(5'd3, 32'h0000_0103, 1'b0, 1'b0);
        do_mem("sb", 5'd3, 32'h103, 32'hAABB_CCDD, F3_B, 1'b1,
               4'b1000, 32'hDDDD_DDDD, 32'd0, 3, 0);
        push(5'd4, 32'h0000_0102, 1'b0, 1'b0);
        do_mem("sh", 5'd4, 32'h102, 32'h1122_3344, F3_H, 1'b1,
               4'b1100, 32'h3344_3344, 32'd0, 1, 0);
        push(5'd6, 32'h0000_0200, 1'b0, 1'b0);
        do_mem("sw", 5'd6, 32'h200, 32'hCAFE_BABE, F3_W, 1'b1,
               4'b1111, 32'hCAFE_BABE, 32'd0, 0, 0);

        push(5'd7, 32'hFFFF_FFF0, 1'b1, 1'b0);
        do_mem("lb", 5'd7, 32'h2, 32'd0, F3_B, 1'b0,
               4'b0, 32'd0, 32'h80F0_7F01, 0, 0);
        push(5'd8, 32'h0000_00F0, 1'b1, 1'b0);
        do_mem("lbu", 5'd8, 32'h2, 32'd0, F3_BU, 1'b0,
               4'b0, 32'd0, 32'h80F0_7F01, 1, 2);
        push(5'd9, 32'hFFFF_80F0, 1'b1, 1'b0);
        do_mem("lh", 5'd9, 32'h2, 32'd0, F3_H, 1'b0,
               4'b0, 32'd0, 32'h80F0_7F01, 0, 1);
        push(5'd10, 32'h80F0_7F01, 1'b1, 1'b0);
        do_mem("lw", 5'd10, 32'h0, 32'd0, F3_W, 1'b0,
               4'b0, 32'd0, 32'h80F0_7F01, 0, 0);
        push(5'd13, 32'h0000_80F0, 1'b1, 1'b0);
        do_mem("lhu", 5'd13, 32'h2, 32'd0, F3_HU, 1'b0,
               4'b0, 32'd0, 32'h80F0_7F01, 0, 0);
        push(5'd14, 32'h0000_007F, 1'b1, 1'b0);
        do_mem("lb1", 5'd14, 32'h1, 32'd0, F3_B, 1'b0,
               4'b0, 32'd0, 32'h80F0_7F01, 0, 0);

        push(5'd11, 32'h0000_0002, 1'b0, 1'b1);
        issue(5'd11, 32'h2, 32'd0, F3_W, 1'b1, 1'b0, 1'b1);
        check("mis_noreq", 32'(dmem_req_valid), 32'd0);
        check("mis_wb", 32'(wb_valid), 32'd1);
        check("mis_err", 32'(access_err), 32'd1);
        tick();
        check("mis_err_pulse", 32'(access_err), 32'd0);

        push(5'd12, 32'h0000_0040, 1'b0, 1'b1);
        issue(5'd12, 32'h40, 32'h1, F3_BU, 1'b0, 1'b1, 1'b1);
        check("badf3_noreq", 32'(dmem_req_valid), 32'd0);
        tick();
        push(5'd15, 32'h0000_0044, 1'b0, 1'b1);
        issue(5'd15, 32'h44, 32'h1, F3_W, 1'b1, 1'b1, 1'b1);
        check("rw_noreq", 32'(dmem_req_valid), 32'd0);
        tick();

        push(5'd0, 32'h1234_5678, 1'b0, 1'b0);
        do_mem("lx0", 5'd0, 32'h10, 32'd0, F3_W, 1'b0,
               4'b0, 32'd0, 32'h1234_5678, 0, 0);
        tick();
        dmem_rsp_valid = 1'b1;
        tick();
        dmem_rsp_valid = 1'b0;
        check("spur_nowb", 32'(wb_valid), 32'd0);
        tick();
        check("spur_nowb2", 32'(wb_valid), 32'd0);
        check("spur_ready", 32'(ex_ready), 32'd1);

        issue(5'd16, 32'h20, 32'd0, F3_W, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10 && !dmem_req_valid; i++) tick();
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_ready", 32'(ex_ready), 32'd1);
        check("mrst_req", 32'(dmem_req_valid), 32'd0);
        check("mrst_wb", 32'(wb_valid), 32'd0);
        check("mrst_rd", 32'(wb_rd), 32'd0);
        check("mrst_data", wb_data, 32'd0);
        tick();
        rst = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hFFFF_0000;
        tick();
        dmem_rsp_valid = 1'b0;
        check("mrst_nowb", 32'(wb_valid), 32'd0);
        check("mrst_idle", 32'(ex_ready), 32'd1);

        push(5'd0, 32'h0000_0077, 1'b0, 1'b0);
        issue(5'd0, 32'h77, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        check("x0_wb", 32'(wb_valid), 32'd1);
        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
